// File: rtl/alu_logic_arb_pkg.sv
// Shared definitions for the Fusion-Core execute-stage logic unit and its
// two-requester arbiter.
//   XLEN         : datapath width of the logic unit
//   logic_op_e   : 2-bit opcode of the bitwise unit (all four codes defined)
//   slot_state_e : occupancy of the one-entry output register
package fc_alu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_ANDN = 2'b11
  } logic_op_e;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/alu_logic_arb_if.sv
// Handshake bundle between the two requesters, the shared logic unit and the
// result consumer.
//   reqN_valid/op/a/b : requester N operation (driven by master)
//   reqN_ready        : requester N accepted this cycle (driven by slave)
//   rsp_valid/id/data/zero : output register contents (driven by slave)
//   rsp_ready         : consumer takes the result (driven by master)
interface alu_logic_arb_if;
  import fc_alu_pkg::*;

  logic            req0_valid;
  logic            req0_ready;
  logic [1:0]      req0_op;
  logic [XLEN-1:0] req0_a;
  logic [XLEN-1:0] req0_b;

  logic            req1_valid;
  logic            req1_ready;
  logic [1:0]      req1_op;
  logic [XLEN-1:0] req1_a;
  logic [XLEN-1:0] req1_b;

  logic            rsp_valid;
  logic            rsp_ready;
  logic            rsp_id;
  logic [XLEN-1:0] rsp_data;
  logic            rsp_zero;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_data, rsp_zero
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_data, rsp_zero
  );

endinterface

// File: rtl/and_32.sv
// 32-bit bitwise AND, the AND path of the shared logic unit.
//   a_i, b_i : operands
//   y_o      : a_i & b_i
module and_32
  import fc_alu_pkg::*;
(
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] y_o
);

  assign y_o = a_i & b_i;

endmodule

// File: rtl/logic_unit_32.sv
// Purely combinational 32-bit bitwise logic unit: AND, OR, XOR, ANDN.
//   op_i     : opcode (logic_op_e)
//   a_i, b_i : operands
//   result_o : op_i applied bitwise to a_i/b_i
module logic_unit_32
  import fc_alu_pkg::*;
(
  input  logic_op_e       op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] result_o
);

  logic [XLEN-1:0] and_res;

  and_32 u_and (
    .a_i (a_i),
    .b_i (b_i),
    .y_o (and_res)
  );

  always_comb begin
    result_o = and_res;
    case (op_i)
      OP_AND:  result_o = and_res;
      OP_OR:   result_o = a_i | b_i;
      OP_XOR:  result_o = a_i ^ b_i;
      OP_ANDN: result_o = a_i & ~b_i;  // only b is inverted
      default: result_o = and_res;
    endcase
  end

endmodule

// File: rtl/alu_logic_arb.sv
// Round-robin arbiter sharing one logic_unit_32 between the integer execute
// pipe (requester 0) and the address/mask path (requester 1). The winning
// operation is computed in the accept cycle and captured in a one-entry
// output register, returned with a valid/ready handshake and requester tag.
//   PRIO_RESET : requester that wins the first contended cycle after reset
//   clk        : rising-edge clock
//   reset_n    : synchronous active-low reset
//   bus        : request/response handshake bundle (slave side)
module alu_logic_arb
  import fc_alu_pkg::*;
#(
  parameter bit PRIO_RESET = 1'b0
) (
  input logic             clk,
  input logic             reset_n,
  alu_logic_arb_if.slave  bus
);

  slot_state_e     state_q, state_d;
  logic            id_q, id_d;
  logic            zero_q, zero_d;
  logic [XLEN-1:0] data_q, data_d;
  logic            last_grant_q, last_grant_d;

  logic            grant0, grant1;
  logic            slot_free;
  logic            acc0, acc1, accept;
  logic_op_e       op_sel;
  logic [XLEN-1:0] a_sel, b_sel;
  logic [XLEN-1:0] result;

  // Contention goes to the requester that did not win last; a lone
  // requester always wins.
  assign grant0 = bus.req0_valid & (~bus.req1_valid | last_grant_q);
  assign grant1 = bus.req1_valid & (~bus.req0_valid | ~last_grant_q);

  // The slot can take a new result when empty or when it drains this cycle.
  // Gating with reset_n keeps both readys low during the reset cycle.
  assign slot_free = reset_n & ((state_q == SLOT_EMPTY) | bus.rsp_ready);

  assign bus.req0_ready = slot_free & grant0;
  assign bus.req1_ready = slot_free & grant1;

  assign acc0   = bus.req0_valid & bus.req0_ready;
  assign acc1   = bus.req1_valid & bus.req1_ready;
  assign accept = acc0 | acc1;

  // Operand mux into the single shared logic unit.
  assign op_sel = grant1 ? logic_op_e'(bus.req1_op) : logic_op_e'(bus.req0_op);
  assign a_sel  = grant1 ? bus.req1_a : bus.req0_a;
  assign b_sel  = grant1 ? bus.req1_b : bus.req0_b;

  logic_unit_32 u_lu (
    .op_i     (op_sel),
    .a_i      (a_sel),
    .b_i      (b_sel),
    .result_o (result)
  );

  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    data_d       = data_q;
    zero_d       = zero_q;
    last_grant_d = last_grant_q;
    if (accept) begin
      // Covers same-cycle drain+accept: the new result replaces the old one.
      state_d      = SLOT_FULL;
      id_d         = acc1;
      data_d       = result;
      zero_d       = (result == '0);
      last_grant_d = acc1;
    end else if ((state_q == SLOT_FULL) && bus.rsp_ready) begin
      // Drain only; data/id keep their last values.
      state_d = SLOT_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= SLOT_EMPTY;
      id_q         <= 1'b0;
      data_q       <= '0;
      zero_q       <= 1'b0;
      last_grant_q <= ~PRIO_RESET;
    end else begin
      state_q      <= state_d;
      id_q         <= id_d;
      data_q       <= data_d;
      zero_q       <= zero_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign bus.rsp_valid = (state_q == SLOT_FULL);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_data  = data_q;
  assign bus.rsp_zero  = zero_q;

endmodule

// File: tb/tb_alu_logic_arb.sv
module tb_alu_logic_arb;

  logic clk;
  logic reset_n;

  int total;
  int bad;

  alu_logic_arb_if bus0 ();
  alu_logic_arb_if bus1 ();

  alu_logic_arb #(.PRIO_RESET(1'b0)) dut0 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus0.slave)
  );

  alu_logic_arb #(.PRIO_RESET(1'b1)) dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic v, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus0.req0_valid = v;
    bus0.req0_op    = op;
    bus0.req0_a     = a;
    bus0.req0_b     = b;
  endtask

  task automatic drv1(input logic v, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus0.req1_valid = v;
    bus0.req1_op    = op;
    bus0.req1_a     = a;
    bus0.req1_b     = b;
  endtask

  task automatic chk_rsp(input string tag, input logic v, input logic id,
                         input logic [31:0] d, input logic z);
    chk({tag, ".valid"}, {31'b0, bus0.rsp_valid}, {31'b0, v});
    chk({tag, ".id"},    {31'b0, bus0.rsp_id},    {31'b0, id});
    chk({tag, ".data"},  bus0.rsp_data,           d);
    chk({tag, ".zero"},  {31'b0, bus0.rsp_zero},  {31'b0, z});
  endtask

  task automatic chk_rdy(input string tag, input logic r0, input logic r1);
    chk({tag, ".rdy0"}, {31'b0, bus0.req0_ready}, {31'b0, r0});
    chk({tag, ".rdy1"}, {31'b0, bus0.req1_ready}, {31'b0, r1});
  endtask

  // Watchdog: the directed sequence is a few dozen cycles.
  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic exp_id;
    total = 0;
    bad   = 0;
    reset_n = 1'b0;
    drv0(1'b0, 2'b00, 32'h0, 32'h0);
    drv1(1'b0, 2'b00, 32'h0, 32'h0);
    bus0.rsp_ready = 1'b0;
    bus1.req0_valid = 1'b0; bus1.req0_op = 2'b00; bus1.req0_a = '0; bus1.req0_b = '0;
    bus1.req1_valid = 1'b0; bus1.req1_op = 2'b00; bus1.req1_a = '0; bus1.req1_b = '0;
    bus1.rsp_ready = 1'b0;
    tick();
    tick();

    // Readys must stay low while reset is asserted, even with a request.
    @(negedge clk);
    drv0(1'b1, 2'b00, 32'hF0F0_FFFF, 32'h0FF0_00FF);
    bus0.rsp_ready = 1'b1;
    #1;
    chk_rdy("in_reset", 1'b0, 1'b0);
    tick();
    chk_rsp("reset", 1'b0, 1'b0, 32'h0, 1'b0);

    // First accept right after reset: AND.
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk_rdy("and0", 1'b1, 1'b0);
    tick();
    chk_rsp("and0", 1'b1, 1'b0, 32'h00F0_00FF, 1'b0);

    // Contention with rsp_ready=1. last_grant is 0 now, so 1,0,1,0.
    @(negedge clk);
    drv0(1'b1, 2'b10, 32'hAAAA_AAAA, 32'h5555_5555);
    drv1(1'b1, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_0000);
    for (int i = 0; i < 4; i++) begin
      exp_id = (i % 2 == 0) ? 1'b1 : 1'b0;
      #1;
      chk_rdy($sformatf("rr%0d", i), ~exp_id, exp_id);
      tick();
      chk_rsp($sformatf("rr%0d", i), 1'b1, exp_id,
              exp_id ? 32'h0000_FFFF : 32'hFFFF_FFFF, 1'b0);
      @(negedge clk);
    end

    // Stall: slot FULL with id0 XOR result, rsp_ready low, req1 waiting.
    drv0(1'b0, 2'b00, 32'h0, 32'h0);
    bus0.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_rdy($sformatf("stall%0d", i), 1'b0, 1'b0);
      tick();
      chk_rsp($sformatf("stall%0d", i), 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0);
      @(negedge clk);
    end
    bus0.rsp_ready = 1'b1;
    #1;
    chk_rdy("unstall", 1'b0, 1'b1);
    tick();
    chk_rsp("unstall", 1'b1, 1'b1, 32'h0000_FFFF, 1'b0);

    // req1 OR.
    @(negedge clk);
    drv1(1'b1, 2'b01, 32'h1234_0000, 32'h0000_5678);
    #1;
    chk_rdy("or1", 1'b0, 1'b1);
    tick();
    chk_rsp("or1", 1'b1, 1'b1, 32'h1234_5678, 1'b0);

    // Drain with no new request: slot empties, data/id held.
    @(negedge clk);
    drv1(1'b0, 2'b00, 32'h0, 32'h0);
    tick();
    chk_rsp("drain", 1'b0, 1'b1, 32'h1234_5678, 1'b0);

    // req0 AND giving zero.
    @(negedge clk);
    drv0(1'b1, 2'b00, 32'hFFFF_0000, 32'h0000_FFFF);
    #1;
    chk_rdy("zero", 1'b1, 1'b0);
    tick();
    chk_rsp("zero", 1'b1, 1'b0, 32'h0000_0000, 1'b1);

    // Fill the slot with a nonzero req1 result and hold it.
    @(negedge clk);
    drv0(1'b0, 2'b00, 32'h0, 32'h0);
    drv1(1'b1, 2'b01, 32'hDEAD_BEEF, 32'h0000_0000);
    tick();
    chk_rsp("fill", 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0);
    @(negedge clk);
    drv1(1'b0, 2'b00, 32'h0, 32'h0);
    bus0.rsp_ready = 1'b0;
    tick();
    chk_rsp("hold", 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0);

    // Reset mid-operation drops the held result.
    @(negedge clk);
    reset_n = 1'b0;
    tick();
    chk_rsp("midrst", 1'b0, 1'b0, 32'h0, 1'b0);

    // Both valid right after reset: PRIO_RESET requester wins on each DUT.
    @(negedge clk);
    reset_n = 1'b1;
    bus0.rsp_ready = 1'b1;
    drv0(1'b1, 2'b01, 32'h0000_00F0, 32'h0000_000F);
    drv1(1'b1, 2'b10, 32'hFFFF_FFFF, 32'h0F0F_0F0F);
    bus1.rsp_ready  = 1'b1;
    bus1.req0_valid = 1'b1; bus1.req0_op = 2'b01; bus1.req0_a = 32'h0000_00F0; bus1.req0_b = 32'h0000_000F;
    bus1.req1_valid = 1'b1; bus1.req1_op = 2'b10; bus1.req1_a = 32'hFFFF_FFFF; bus1.req1_b = 32'h0F0F_0F0F;
    #1;
    chk_rdy("prio0", 1'b1, 1'b0);
    chk("prio1.rdy0", {31'b0, bus1.req0_ready}, 32'd0);
    chk("prio1.rdy1", {31'b0, bus1.req1_ready}, 32'd1);
    tick();
    chk_rsp("prio0", 1'b1, 1'b0, 32'h0000_00FF, 1'b0);
    chk("prio1.valid", {31'b0, bus1.rsp_valid}, 32'd1);
    chk("prio1.id",    {31'b0, bus1.rsp_id},    32'd1);
    chk("prio1.data",  bus1.rsp_data,           32'hF0F0_F0F0);

    @(negedge clk);
    drv0(1'b0, 2'b00, 32'h0, 32'h0);
    drv1(1'b0, 2'b00, 32'h0, 32'h0);
    bus1.req0_valid = 1'b0;
    bus1.req1_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
